// File: rtl/decode_pkg.sv
// Shared widths, types and the reference one-hot function for the decoder family.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package decode_pkg;

  localparam int SEL_W    = 3;
  localparam int ONEHOT_W = 8;

  typedef logic [SEL_W-1:0]    sel_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  // Binary select to one-hot: bit k set when sel == k.
  function automatic onehot_t onehot_fn(input sel_t sel);
    onehot_t result;
    result = onehot_t'(1) << sel;
    return result;
  endfunction

endpackage

// File: rtl/decode_2_to_4.sv
// Combinational 2-to-4 one-hot decoder with enable; leaf of larger decode trees.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs directly.
module decode_2_to_4 (
  input  logic [1:0] IN,
  input  logic       ENABLE,
  output logic [3:0] OUT
);

  // Gate the shifted one-hot with ENABLE so a disabled leaf contributes no bits.
  always_comb begin
    OUT = 4'h0;
    if (ENABLE) begin
      OUT = 4'b0001 << IN;
    end
  end

endmodule

// File: rtl/decode_3_to_8.sv
// Registered 3-to-8 one-hot decoder with enable, built from two 2-to-4 leaves.
// Latency: 1 cycle from IN/ENABLE to OUT; synchronous active-high RESET loads RESET_OUT.
// Backpressure: none. Build option DECODE_HOLD_EN makes ENABLE=0 hold OUT instead of clearing it.
module decode_3_to_8
  import decode_pkg::*;
#(
  parameter onehot_t RESET_OUT = 8'h00
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [2:0]    IN,
  input  logic          ENABLE,
  output logic [7:0]    OUT
);

  // RESET_OUT must keep OUT at most one-hot, otherwise downstream write selects collide.
  if ($countones(RESET_OUT) > 1) begin : g_bad_reset_out
    $error("RESET_OUT must be zero or one-hot");
  end

  logic       en_lo;
  logic       en_hi;
  logic [3:0] lo4;
  logic [3:0] hi4;
  onehot_t    dec_d;

  // IN[2] steers ENABLE to exactly one of the two leaves, so at most one leaf drives a bit.
  always_comb begin
    en_lo = ENABLE & ~IN[2];
    en_hi = ENABLE &  IN[2];
  end

  decode_2_to_4 u_dec_lo (
    .IN     (IN[1:0]),
    .ENABLE (en_lo),
    .OUT    (lo4)
  );

  decode_2_to_4 u_dec_hi (
    .IN     (IN[1:0]),
    .ENABLE (en_hi),
    .OUT    (hi4)
  );

  // Upper leaf covers selects 4..7, lower leaf 0..3.
  always_comb begin
    dec_d = {hi4, lo4};
  end

  // Output register: reset wins over ENABLE; with hold enabled, ENABLE acts as a clock enable.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT <= RESET_OUT;
`ifdef DECODE_HOLD_EN
    end else if (ENABLE) begin
      OUT <= dec_d;
`else
    end else begin
      // dec_d is already all-zero when ENABLE=0 because both leaves are gated.
      OUT <= dec_d;
`endif
    end
  end

endmodule

// File: tb/tb_decode_3_to_8.sv
// Self-checking bench for decode_3_to_8 and a standalone decode_2_to_4.
// Expected outputs are queued at drive time and compared one edge later.
// Build with DECODE_HOLD_EN defined to exercise the hold variant.
module tb_decode_3_to_8;
  import decode_pkg::*;

  localparam logic [7:0] MAP [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                       8'h10, 8'h20, 8'h40, 8'h80};
  localparam logic [3:0] SUB_MAP [0:7] = '{4'h0, 4'h0, 4'h0, 4'h0,
                                           4'h1, 4'h2, 4'h4, 4'h8};

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [2:0] IN = 3'd0;
  logic       ENABLE = 1'b0;
  logic [7:0] OUT;

  logic [1:0] sub_in = 2'd0;
  logic       sub_en = 1'b0;
  logic [3:0] sub_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] model = 8'h00;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 CLK = ~CLK;

  decode_3_to_8 #(.RESET_OUT(8'h00)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .IN     (IN),
    .ENABLE (ENABLE),
    .OUT    (OUT)
  );

  decode_2_to_4 sub (
    .IN     (sub_in),
    .ENABLE (sub_en),
    .OUT    (sub_out)
  );

  // Drive one cycle of stimulus, queue the expected OUT, then check it after the edge.
  task automatic step(input logic r, input logic e, input logic [2:0] i, input string tag);
    logic [7:0] exp_v;
    string      exp_tag;
    @(negedge CLK);
    RESET  = r;
    ENABLE = e;
    IN     = i;
    if (r) begin
      model = 8'h00;
    end else if (e) begin
      model = MAP[i];
    end else begin
`ifdef DECODE_HOLD_EN
      model = model;
`else
      model = 8'h00;
`endif
    end
    exp_q.push_back(model);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    exp_v   = exp_q.pop_front();
    exp_tag = tag_q.pop_front();
    total++;
    assert (OUT === exp_v) else begin
      bad++;
      $error("FAIL %s r=%0b e=%0b in=%0d observed=%h expected=%h", exp_tag, r, e, i, OUT, exp_v);
    end
    total++;
    assert ($onehot0(OUT)) else begin
      bad++;
      $error("FAIL onehot0_%s observed=%h expected=at most one bit set", exp_tag, OUT);
    end
  endtask

  initial begin
    // Reset dominates ENABLE=1, IN=5 for two edges, then release decodes IN=5.
    step(1'b1, 1'b1, 3'd5, "reset0");
    step(1'b1, 1'b1, 3'd5, "reset1");
    step(1'b0, 1'b1, 3'd5, "release");

    // Sweep every select with ENABLE high.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 3'(k), $sformatf("sweep%0d", k));
    end

    // Enable off after a decoded value.
    step(1'b0, 1'b1, 3'd3, "en_on3");
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 3'(k), $sformatf("en_off%0d", k));
    end

    // Hold scenario: clears in the default build, holds 8'h40 with DECODE_HOLD_EN.
    step(1'b0, 1'b1, 3'd6, "hold_load");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 3'd1, $sformatf("hold%0d", k));
    end
    step(1'b1, 1'b0, 3'd1, "hold_reset");

    // Random mix of reset, enable and select.
    for (int k = 0; k < 1000; k++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), "random");
    end

    // Package reference function against the literal mapping table.
    for (int k = 0; k < 8; k++) begin
      total++;
      assert (onehot_fn(sel_t'(k)) === MAP[k]) else begin
        bad++;
        $error("FAIL onehot_fn%0d observed=%h expected=%h", k, onehot_fn(sel_t'(k)), MAP[k]);
      end
    end

    // Standalone 2-to-4 leaf, ENABLE=0 rows first.
    for (int k = 0; k < 8; k++) begin
      sub_en = k[2];
      sub_in = k[1:0];
      #1;
      total++;
      assert (sub_out === SUB_MAP[k]) else begin
        bad++;
        $error("FAIL sub%0d en=%0b in=%0d observed=%h expected=%h",
               k, sub_en, sub_in, sub_out, SUB_MAP[k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
